// File: rtl/reaction_timer_core.sv
// rtl/reaction_timer_core.sv - reaction-timer trial FSM, ms prescaler, LFSR delay, BCD result
// Optional best-time register enabled by defining BEST_TIME_EN.
module reaction_timer_core #(
    parameter int unsigned TICK_DIV    = 100_000,
    parameter int unsigned MIN_WAIT_MS = 1000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        react_btn,
    input  logic        test_mode,
    output logic [15:0] digits,
    output logic [15:0] led,
    output logic        result_valid,
    output logic        busy
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STIM   = 3'd2;
    localparam logic [2:0] S_RESULT = 3'd3;
    localparam logic [2:0] S_FALSE  = 3'd4;

    logic [2:0]    state, state_d;
    logic          start_q, react_q;
    logic [15:0]   lfsr;
    logic [PW-1:0] prescaler;
    logic [15:0]   wait_cnt, wait_d;
    logic [15:0]   bcd, bcd_d;
    logic [15:0]   latched, latched_d;
    logic [15:0]   idle_digits;
    logic [15:0]   digits_d, led_d;
    logic          valid_d, busy_d;
    logic          start_rise, react_rise, tick;
    logic [15:0]   bcd_next;

    assign start_rise = start_btn & ~start_q;
    assign react_rise = react_btn & ~react_q;
    assign tick       = (prescaler == PW'(TICK_DIV - 1));

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign bcd_next = bcd_inc(bcd);

    always_comb begin
        state_d   = state;
        wait_d    = wait_cnt;
        bcd_d     = bcd;
        latched_d = latched;
        case (state)
            S_IDLE, S_RESULT, S_FALSE: begin
                if (start_rise) begin
                    state_d = S_WAIT;
                    wait_d  = 16'(MIN_WAIT_MS) + (test_mode ? 16'd0 : {5'd0, lfsr[10:0]});
                    bcd_d   = 16'h0000;
                end
            end
            S_WAIT: begin
                // react has priority over the delay expiring: a press on that edge is still early
                if (react_rise) begin
                    state_d = S_FALSE;
                end else if (tick) begin
                    if (wait_cnt == 16'd1) begin
                        state_d = S_STIM;
                        bcd_d   = 16'h0000;
                    end else begin
                        wait_d = wait_cnt - 16'd1;
                    end
                end
            end
            S_STIM: begin
                if (react_rise) begin
                    state_d   = S_RESULT;
                    latched_d = bcd;
                end else if (tick) begin
                    bcd_d = bcd_next;
                    if (bcd_next == 16'h9999) begin
                        state_d   = S_RESULT;
                        latched_d = 16'h9999;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef BEST_TIME_EN
    logic [15:0] best;

    assign idle_digits = best;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            best <= 16'h9999;
        end else if (state_d == S_RESULT && state != S_RESULT &&
                     latched_d != 16'h9999 && latched_d < best) begin
            best <= latched_d;
        end
    end
`else
    assign idle_digits = 16'h0000;
`endif

    // Outputs decode the next state so they change on the same edge as the transition
    always_comb begin
        digits_d = 16'h0000;
        led_d    = 16'h0000;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        case (state_d)
            S_IDLE:   digits_d = idle_digits;
            S_WAIT:   busy_d = 1'b1;
            S_STIM: begin
                digits_d = bcd_d;
                led_d    = 16'hFFFF;
                busy_d   = 1'b1;
            end
            S_RESULT: begin
                digits_d = latched_d;
                led_d    = 16'h0001;
                valid_d  = 1'b1;
            end
            S_FALSE: begin
                digits_d = 16'hEEEE;
                led_d    = 16'hAAAA;
            end
            default: digits_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            start_q      <= 1'b0;
            react_q      <= 1'b0;
            lfsr         <= LFSR_SEED;
            prescaler    <= '0;
            wait_cnt     <= 16'd0;
            bcd          <= 16'h0000;
            latched      <= 16'h0000;
            digits       <= 16'h0000;
            led          <= 16'h0000;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            start_q      <= start_btn;
            react_q      <= react_btn;
            lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            prescaler    <= (state_d != state || tick) ? '0 : prescaler + 1'b1;
            wait_cnt     <= wait_d;
            bcd          <= bcd_d;
            latched      <= latched_d;
            digits       <= digits_d;
            led          <= led_d;
            result_valid <= valid_d;
            busy         <= busy_d;
        end
    end
endmodule
